// File: rtl/rps_arb.sv
// -----------------------------------------------------------------------------
// rps_arb -- parametrised rotating-priority (round-robin) arbiter.
//
// Grants at most one of N requesters per cycle. The grant is registered and
// one-hot. The priority pointer moves to the index just past the most recent
// winner, so every persistent requester is served within N grants.
//
// Optional feature macro: RPS_ARB_LOCK_EN
//   defined   : a holder that keeps req and lock asserted (with en=1) is
//               re-granted and the pointer is frozen for the lock's duration.
//   undefined : the lock port is present but has no effect; every cycle
//               arbitrates normally.
//
// Parameters
//   N      number of requesters (>= 2, any value, not only powers of two)
//   PTR_W  index width, derived from N (do not override)
//
// Ports
//   clock    in   1      rising-edge system clock
//   reset    in   1      asynchronous active-high reset
//   req      in   N      request vector, bit i = requester i
//   en       in   1      arbitration enable; 0 forces no grant
//   lock     in   1      holder asks to keep its grant (lock build only)
//   gnt      out  N      registered one-hot (or zero) grant
//   gnt_idx  out  PTR_W  binary index of the granted requester, 0 if none
//   valid    out  1      grant present
//   count    out  PTR_W  priority pointer for the next arbitration
// -----------------------------------------------------------------------------
module rps_arb #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             lock,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             valid,
  output logic [PTR_W-1:0] count
);

  // Highest legal index; incrementing past it wraps explicitly to zero so
  // pointer values >= N can never be produced.
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);
  // N held one bit wider than the pointer so count+offset never overflows.
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W + 1)'(N);

`ifdef RPS_ARB_LOCK_EN
  localparam logic LOCK_ON = 1'b1;
`else
  localparam logic LOCK_ON = 1'b0;
`endif

  // Registered state
  logic [N-1:0]     gnt_r;
  logic [PTR_W-1:0] gnt_idx_r;
  logic             valid_r;
  logic [PTR_W-1:0] count_r;
  logic             lock_flag_r;

  // Next-state values
  logic [N-1:0]     gnt_nxt_s;
  logic [PTR_W-1:0] gnt_idx_nxt_s;
  logic             valid_nxt_s;
  logic [PTR_W-1:0] count_nxt_s;
  logic             lock_flag_nxt_s;

  // Search results
  logic [PTR_W:0]   cand_s;
  logic             win_found_s;
  logic [PTR_W-1:0] win_idx_s;
  logic [N-1:0]     win_onehot_s;
  logic [PTR_W-1:0] win_inc_s;
  logic             keep_s;

  // Rotating search: visit count, count+1, ..., wrapping mod N; first hit wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    cand_s      = {(PTR_W + 1){1'b0}};
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, count_r} + (PTR_W + 1)'(k);
      cand_s = (cand_s >= N_EXT) ? (cand_s - N_EXT) : cand_s;
      if (!win_found_s && req[cand_s[PTR_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        win_found_s = win_found_s;
        win_idx_s   = win_idx_s;
      end
    end
  end

  // Decode the winner to one-hot and form the pointer value just past it.
  always_comb begin
    win_onehot_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      win_onehot_s[i] = win_found_s && (win_idx_s == PTR_W'(i));
    end
    if (win_idx_s == LAST_IDX) begin
      win_inc_s = {PTR_W{1'b0}};
    end else begin
      win_inc_s = win_idx_s + PTR_W'(1);
    end
  end

  // Lock hold condition. A set lock flag always coincides with a valid grant,
  // so OR-ing it into the validity term does not change the condition.
  always_comb begin
    keep_s = LOCK_ON && en && lock && (valid_r || lock_flag_r) && req[gnt_idx_r];
  end

  // Next-state selection: disable, lock repeat, fresh grant or idle.
  always_comb begin
    gnt_nxt_s       = {N{1'b0}};
    gnt_idx_nxt_s   = {PTR_W{1'b0}};
    valid_nxt_s     = 1'b0;
    count_nxt_s     = count_r;
    lock_flag_nxt_s = 1'b0;
    if (!en) begin
      // Nothing granted, pointer held, lock released.
      gnt_nxt_s       = {N{1'b0}};
      gnt_idx_nxt_s   = {PTR_W{1'b0}};
      valid_nxt_s     = 1'b0;
      count_nxt_s     = count_r;
      lock_flag_nxt_s = 1'b0;
    end else if (keep_s) begin
      // Repeat the grant; the pointer already sits past the holder.
      gnt_nxt_s       = gnt_r;
      gnt_idx_nxt_s   = gnt_idx_r;
      valid_nxt_s     = 1'b1;
      count_nxt_s     = count_r;
      lock_flag_nxt_s = 1'b1;
    end else if (win_found_s) begin
      gnt_nxt_s       = win_onehot_s;
      gnt_idx_nxt_s   = win_idx_s;
      valid_nxt_s     = 1'b1;
      count_nxt_s     = win_inc_s;
      lock_flag_nxt_s = 1'b0;
    end else begin
      // Enabled but nobody requesting: idle, pointer held.
      gnt_nxt_s       = {N{1'b0}};
      gnt_idx_nxt_s   = {PTR_W{1'b0}};
      valid_nxt_s     = 1'b0;
      count_nxt_s     = count_r;
      lock_flag_nxt_s = 1'b0;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_r       <= {N{1'b0}};
      gnt_idx_r   <= {PTR_W{1'b0}};
      valid_r     <= 1'b0;
      count_r     <= {PTR_W{1'b0}};
      lock_flag_r <= 1'b0;
    end else begin
      gnt_r       <= gnt_nxt_s;
      gnt_idx_r   <= gnt_idx_nxt_s;
      valid_r     <= valid_nxt_s;
      count_r     <= count_nxt_s;
      lock_flag_r <= lock_flag_nxt_s;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    gnt     = gnt_r;
    gnt_idx = gnt_idx_r;
    valid   = valid_r;
    count   = count_r;
  end

endmodule

// File: doc/rps_arb.md
# rps_arb

Parametrised rotating-priority arbiter: the N-requester successor to the fixed 4-input rotating priority selector. It grants at most one of N requesters per cycle through a registered one-hot grant. The priority pointer advances past the most recent winner, which gives true round-robin fairness. An optional grant-lock mode lets a winner hold the grant across multi-cycle transactions. It sits in front of shared resources (memory port, bus, functional unit) wherever more than four clients contend.

## Interface
- `N`, default 4: number of requesters; legal range ≥ 2; need not be a power of two.
- `PTR_W`, default `$clog2(N)`: pointer/index width; derived, never overridden.

- `clock`  input  1  single system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  N  request vector; bit i = requester i.
- `en`  input  1  arbitration enable; 0 forces no grant.
- `lock`  input  1  the current holder requests to keep its grant (only effective with `RPS_ARB_LOCK_EN`).
- `gnt`  output  N  registered one-hot (or zero) grant.
- `gnt_idx`  output  PTR_W  binary index of the granted requester; 0 when `valid`=0.
- `valid`  output  1  1 when `gnt` is nonzero.
- `count`  output  PTR_W  current priority pointer, i.e. the highest-priority index for the next arbitration.

## Operation
- Reset value of every output and state element is 0: `gnt`, `gnt_idx`, `valid`, `count`, and the internal lock flag.
- Each rising edge with `en`=1, the next grant is computed from the current `req`:
  - Search indices `count`, `count`+1, … , N-1, 0, … , `count`-1.
  - The first index with `req` set wins.
  - `gnt` receives the one-hot of winner w, `gnt_idx` receives w, and `valid` receives 1.
  - `count` receives (w+1) mod N.
- `en`=1 and `req`=0: `gnt`, `gnt_idx` and `valid` become 0; `count` is held.
- `en`=0: `gnt`, `gnt_idx` and `valid` become 0; `count` is held; the lock flag is cleared.
- Pointer arithmetic is mod N. For non-power-of-two N, the increment from N-1 wraps explicitly to 0; pointer values ≥ N are unreachable.
- At most one bit of `gnt` is ever set.
- Lock behaviour (macro defined):
  - If `valid`=1, the holder's `req` bit is still 1, `lock`=1 and `en`=1, the grant repeats to the same holder.
  - During a lock, `count` is unchanged; it already points past the holder.
  - If the holder drops `req` or `lock`, normal arbitration runs in that same cycle. No idle bubble is inserted.

## Timing
- Latency: one cycle from `req`/`en` sampled at edge k to `gnt` valid after edge k.
- `gnt` is a registered output; there is no combinational path from `req` to `gnt`.
- `gnt`, `gnt_idx`, `valid` and `count` all change only on the same edge, except under reset.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.
- The first grant after reset deasserts appears at the first rising edge with `en`=1 and any `req`. Priority starts at index 0.
- A requester that drops `req` in the cycle it is granted still receives that registered grant for one cycle. Requesters must tolerate this.

## Configuration
- `RPS_ARB_LOCK_EN` defined: lock behaviour as described above. The internal flag tracks that the holder is locked.
- `RPS_ARB_LOCK_EN` undefined:
  - The `lock` port still exists, so the interface is unchanged, but it is ignored.
  - Every cycle arbitrates normally.
  - A continuously requesting holder is preempted in round-robin order.

## Test plan
- Fill rotation: N=4, after reset, `en`=1, `req`=1111 for 5 cycles → `gnt` = 0001, 0010, 0100, 1000, 0001; `count` = 1, 2, 3, 0, 1; `gnt_idx` = 0, 1, 2, 3, 0.
- Wrap search: N=4, after reset, `req`=0100 → `gnt`=0100, `count`=3. Then `req`=0101 → `gnt`=0001, `count`=1.
- Disable: N=4, `en`=0, `req`=1111 for 2 cycles → `gnt`=0000, `valid`=0, `count` held at its prior value.
- Lock (macro defined): N=4, after reset, `req`=0011, `lock`=1 for 3 cycles → `gnt`=0001 on all three, `count`=1. Drop `lock` → next `gnt`=0010, `count`=2. With the macro undefined, the same stimulus gives `gnt` = 0001, 0010, 0001.
- Non-power-of-two: N=5, `req`=11111 for 6 cycles → `gnt_idx` = 0, 1, 2, 3, 4, 0; `count` wraps 4 → 0, never reaching 5–7.
- Async reset: with `gnt`=0100, assert `reset` between edges → `gnt`, `valid`, `count` and `gnt_idx` read 0 before the next rising edge. Release reset, `req`=1111 → `gnt`=0001.
